// File: rtl/rk_time_stepper.sv
// Fixed-point time stepper: advances a signed time value by a latched step H
// from T0 towards T_END, then clamps and stops (MODE 0) or wraps to T0 (MODE 1).
module rk_time_stepper #(
  parameter int IW = 16,
  parameter int FW = 16,
  parameter int CW = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                ABORT,
  input  logic                STEP_EN,
  input  logic                MODE,
  input  logic [IW+FW-1:0]    T0,
  input  logic [IW+FW-1:0]    H,
  input  logic [IW+FW-1:0]    T_END,
  output logic [IW+FW-1:0]    COUNT,
  output logic [CW-1:0]       STEP_IDX,
  output logic                BUSY,
  output logic                DONE,
  output logic                WRAP,
  output logic                ERR
);

  localparam int N = IW + FW;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]             state_p0;
  logic signed [N-1:0]    count_p0;
  logic [CW-1:0]          idx_p0;
  logic                   done_p0;
  logic                   wrap_p0;
  logic                   err_p0;
  logic signed [N-1:0]    t0_q;
  logic signed [N-1:0]    h_q;
  logic signed [N-1:0]    tend_q;
  logic                   mode_q;

  logic signed [N-1:0]    t0_in;
  logic signed [N-1:0]    h_in;
  logic signed [N-1:0]    tend_in;
  logic signed [N:0]      nxt_sum;
  logic signed [N:0]      tend_ext;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    sat_inc = (&v) ? v : v + {{(CW-1){1'b0}}, 1'b1};
  endfunction

  assign t0_in   = T0;
  assign h_in    = H;
  assign tend_in = T_END;

  // One guard bit on both operands makes the sum and the end-time compare overflow-free.
  assign nxt_sum  = {count_p0[N-1], count_p0} + {h_q[N-1], h_q};
  assign tend_ext = {tend_q[N-1], tend_q};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_p0 <= ST_IDLE;
      count_p0 <= '0;
      idx_p0   <= '0;
      done_p0  <= 1'b0;
      wrap_p0  <= 1'b0;
      err_p0   <= 1'b0;
      t0_q     <= '0;
      h_q      <= '0;
      tend_q   <= '0;
      mode_q   <= 1'b0;
    end else begin
      done_p0 <= 1'b0;
      wrap_p0 <= 1'b0;
      case (state_p0)
        ST_IDLE: begin
          if (START) begin
            if (h_in <= 0) begin
              err_p0 <= 1'b1;
            end else begin
              count_p0 <= t0_in;
              idx_p0   <= '0;
              err_p0   <= 1'b0;
              if (tend_in > t0_in) begin
                t0_q     <= t0_in;
                h_q      <= h_in;
                tend_q   <= tend_in;
                mode_q   <= MODE;
                state_p0 <= ST_RUN;
              end else begin
                // Empty interval: report completion without ever entering RUN.
                done_p0 <= 1'b1;
              end
            end
          end
        end
        ST_RUN: begin
          if (ABORT) begin
            state_p0 <= ST_IDLE;
          end else if (STEP_EN) begin
            if (nxt_sum < tend_ext) begin
              count_p0 <= nxt_sum[N-1:0];
              idx_p0   <= sat_inc(idx_p0);
            end else if (!mode_q) begin
              count_p0 <= tend_q;
              idx_p0   <= sat_inc(idx_p0);
              done_p0  <= 1'b1;
              state_p0 <= ST_IDLE;
            end else begin
              count_p0 <= t0_q;
              idx_p0   <= '0;
              wrap_p0  <= 1'b1;
            end
          end
        end
        default: state_p0 <= ST_IDLE;
      endcase
    end
  end

  assign COUNT    = count_p0;
  assign STEP_IDX = idx_p0;
  assign BUSY     = (state_p0 == ST_RUN);
  assign DONE     = done_p0;
  assign WRAP     = wrap_p0;
  assign ERR      = err_p0;

endmodule

// File: tb/tb_rk_time_stepper.sv
// Scoreboard bench for rk_time_stepper: stimulus queues hand-computed outputs per
// clock edge, a monitor pops and compares them after each edge.
module tb_rk_time_stepper;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic        STEP_EN = 1'b0;
  logic        MODE = 1'b0;
  logic [31:0] T0 = '0;
  logic [31:0] H = '0;
  logic [31:0] T_END = '0;
  logic [31:0] COUNT;
  logic [15:0] STEP_IDX;
  logic        BUSY, DONE, WRAP, ERR;

  rk_time_stepper #(.IW(16), .FW(16), .CW(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .STEP_EN(STEP_EN),
    .MODE(MODE), .T0(T0), .H(H), .T_END(T_END), .COUNT(COUNT),
    .STEP_IDX(STEP_IDX), .BUSY(BUSY), .DONE(DONE), .WRAP(WRAP), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned cyc;
    logic [31:0] c;
    logic [15:0] i;
    logic        b, d, w, e;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: after each edge, check the expectation queued for that edge.
  always @(posedge CLK) begin
    exp_t x;
    #3;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      x = sb.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL %s: expectation for edge %0d never checked (now %0d)", x.nm, x.cyc, cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      x = sb.pop_front();
      n_cmp++;
      if ({COUNT, STEP_IDX, BUSY, DONE, WRAP, ERR} !== {x.c, x.i, x.b, x.d, x.w, x.e}) begin
        n_fail++;
        $display("FAIL %s: got count=%h idx=%0d busy=%b done=%b wrap=%b err=%b, want count=%h idx=%0d busy=%b done=%b wrap=%b err=%b",
                 x.nm, COUNT, STEP_IDX, BUSY, DONE, WRAP, ERR, x.c, x.i, x.b, x.d, x.w, x.e);
      end
    end
  end

  // Queue the outputs expected after the next edge, then advance one cycle.
  task automatic tick(input string nm, input logic [31:0] c, input logic [15:0] i,
                      input logic b, input logic d, input logic w, input logic e);
    exp_t x;
    x.cyc = cyc + 1; x.c = c; x.i = i; x.b = b; x.d = d; x.w = w; x.e = e; x.nm = nm;
    sb.push_back(x);
    @(posedge CLK);
    #1;
    START = 1'b0;
    ABORT = 1'b0;
  endtask

  task automatic setup(input logic m, input logic [31:0] t0v, input logic [31:0] hv,
                       input logic [31:0] tev);
    MODE = m; T0 = t0v; H = hv; T_END = tev; START = 1'b1;
  endtask

  initial begin
    // Reset wins over a simultaneous START.
    setup(1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0005_0000);
    tick("rst_prio", 32'h0, 16'd0, 0, 0, 0, 0);
    RST = 1'b0;
    tick("rst_idle", 32'h0, 16'd0, 0, 0, 0, 0);

    // Half-step run to 2.0.
    setup(1'b0, 32'h0, 32'h0000_8000, 32'h0002_0000);
    tick("stop_start", 32'h0, 16'd0, 1, 0, 0, 0);
    STEP_EN = 1'b1;
    tick("stop_s1", 32'h0000_8000, 16'd1, 1, 0, 0, 0);
    tick("stop_s2", 32'h0001_0000, 16'd2, 1, 0, 0, 0);
    tick("stop_s3", 32'h0001_8000, 16'd3, 1, 0, 0, 0);
    tick("stop_s4", 32'h0002_0000, 16'd4, 0, 1, 0, 0);
    tick("stop_idle", 32'h0002_0000, 16'd4, 0, 0, 0, 0);
    STEP_EN = 1'b0;

    // Overshoot is clamped to T_END; a STEP_EN-low cycle holds.
    setup(1'b0, 32'h0, 32'h0000_C000, 32'h0001_0000);
    tick("clamp_start", 32'h0, 16'd0, 1, 0, 0, 0);
    tick("clamp_hold", 32'h0, 16'd0, 1, 0, 0, 0);
    STEP_EN = 1'b1;
    tick("clamp_s1", 32'h0000_C000, 16'd1, 1, 0, 0, 0);
    tick("clamp_s2", 32'h0001_0000, 16'd2, 0, 1, 0, 0);
    STEP_EN = 1'b0;
    tick("clamp_idle", 32'h0001_0000, 16'd2, 0, 0, 0, 0);

    // Wrap mode; inputs changed mid-run and a START during RUN must be ignored.
    setup(1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0003_0000);
    tick("wrap_start", 32'h0001_0000, 16'd0, 1, 0, 0, 0);
    STEP_EN = 1'b1; T0 = 32'h0; H = 32'h0005_0000; MODE = 1'b0; T_END = 32'h0009_0000;
    tick("wrap_s1", 32'h0002_0000, 16'd1, 1, 0, 0, 0);
    tick("wrap_s2", 32'h0001_0000, 16'd0, 1, 0, 1, 0);
    tick("wrap_s3", 32'h0002_0000, 16'd1, 1, 0, 0, 0);
    tick("wrap_s4", 32'h0001_0000, 16'd0, 1, 0, 1, 0);
    tick("wrap_s5", 32'h0002_0000, 16'd1, 1, 0, 0, 0);
    STEP_EN = 1'b0; START = 1'b1;
    tick("wrap_start_ign", 32'h0002_0000, 16'd1, 1, 0, 0, 0);
    ABORT = 1'b1;
    tick("wrap_abort", 32'h0002_0000, 16'd1, 0, 0, 0, 0);
    tick("wrap_idle", 32'h0002_0000, 16'd1, 0, 0, 0, 0);

    // Sum exceeds the positive range of N bits but must still clamp, not wrap.
    setup(1'b0, 32'h7FFF_0000, 32'h0002_0000, 32'h7FFF_FFFF);
    tick("big_start", 32'h7FFF_0000, 16'd0, 1, 0, 0, 0);
    STEP_EN = 1'b1;
    tick("big_s1", 32'h7FFF_FFFF, 16'd1, 0, 1, 0, 0);
    STEP_EN = 1'b0;
    tick("big_idle", 32'h7FFF_FFFF, 16'd1, 0, 0, 0, 0);

    // Negative step rejected with sticky ERR; empty interval completes immediately.
    setup(1'b0, 32'h0, 32'hFFFF_0000, 32'h0001_0000);
    tick("err_set", 32'h7FFF_FFFF, 16'd1, 0, 0, 0, 1);
    tick("err_sticky", 32'h7FFF_FFFF, 16'd1, 0, 0, 0, 1);
    setup(1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
    tick("degen_done", 32'h0001_0000, 16'd0, 0, 1, 0, 0);
    tick("degen_idle", 32'h0001_0000, 16'd0, 0, 0, 0, 0);

    // ABORT beats a simultaneous STEP_EN; STEP_EN in IDLE is ignored.
    setup(1'b0, 32'h0, 32'h0001_0000, 32'h0010_0000);
    tick("abort_start", 32'h0, 16'd0, 1, 0, 0, 0);
    STEP_EN = 1'b1;
    tick("abort_s1", 32'h0001_0000, 16'd1, 1, 0, 0, 0);
    tick("abort_s2", 32'h0002_0000, 16'd2, 1, 0, 0, 0);
    ABORT = 1'b1;
    tick("abort_hit", 32'h0002_0000, 16'd2, 0, 0, 0, 0);
    tick("abort_step_ign", 32'h0002_0000, 16'd2, 0, 0, 0, 0);
    STEP_EN = 1'b0;

    // Reset in the middle of a run clears everything.
    setup(1'b0, 32'h0, 32'h0001_0000, 32'h0010_0000);
    tick("mrst_start", 32'h0, 16'd0, 1, 0, 0, 0);
    STEP_EN = 1'b1;
    tick("mrst_s1", 32'h0001_0000, 16'd1, 1, 0, 0, 0);
    RST = 1'b1;
    tick("mrst_hit", 32'h0, 16'd0, 0, 0, 0, 0);
    RST = 1'b0; STEP_EN = 1'b0;
    tick("mrst_idle", 32'h0, 16'd0, 0, 0, 0, 0);

    repeat (3) @(posedge CLK);
    #5;
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rk_time_stepper.md
RK_TIME_STEPPER -- requirements
Module: rk_time_stepper

Interface
REQ-001 The block SHALL have parameter IW, default 16, integer bits of the signed fixed-point time value.
REQ-002 The block SHALL have parameter FW, default 16, fraction bits; N = IW+FW is the data width (default Q16.16, 32 bits).
REQ-003 The block SHALL have parameter CW, default 16, width of the step-index counter.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of CLK.
REQ-005 CLK  input  1  rising-edge clock.
REQ-006 RST  input  1  synchronous reset, active high.
REQ-007 START  input  1  begin a run; sampled only in IDLE.
REQ-008 ABORT  input  1  terminate a run; sampled only in RUN.
REQ-009 STEP_EN  input  1  advance time by one step; sampled only in RUN.
REQ-010 MODE  input  1  sampled at START: 0 = stop at T_END, 1 = wrap to T0 and continue.
REQ-011 T0  input  N  signed start time, sampled at START.
REQ-012 H  input  N  signed step size, sampled at START.
REQ-013 T_END  input  N  signed end time, sampled at START.
REQ-014 COUNT  output  N  current time value, registered.
REQ-015 STEP_IDX  output  CW  steps taken since START or since the last wrap, registered.
REQ-016 BUSY  output  1  high while in RUN.
REQ-017 DONE  output  1  one-cycle pulse on run completion.
REQ-018 WRAP  output  1  one-cycle pulse on each wrap in MODE 1.
REQ-019 ERR  output  1  sticky flag for a rejected START; cleared by the next accepted START or by RST.

Function
REQ-020 The FSM SHALL have exactly two states, IDLE and RUN.
REQ-021 On START in IDLE with H > 0 and T_END > T0: latch T0, H, T_END and MODE; set COUNT <= T0, STEP_IDX <= 0, ERR <= 0; enter RUN on the same edge.
REQ-022 On START in IDLE with H <= 0 (signed): set ERR <= 1, stay in IDLE, leave COUNT unchanged.
REQ-023 On START in IDLE with H > 0 and T_END <= T0: set COUNT <= T0, STEP_IDX <= 0, pulse DONE next cycle, stay in IDLE, leave ERR at 0.
REQ-024 In RUN with STEP_EN low, COUNT and STEP_IDX SHALL hold.
REQ-025 In RUN with STEP_EN high, compute nxt = COUNT + H as an (N+1)-bit signed sum, so no overflow is possible.
REQ-026 If nxt < T_END: COUNT <= nxt[N-1:0]; STEP_IDX <= STEP_IDX+1, saturating at all-ones.
REQ-027 If nxt >= T_END and latched MODE = 0: COUNT <= T_END exactly (clamp); STEP_IDX increments; go to IDLE; DONE = 1 for the following cycle only.
REQ-028 If nxt >= T_END and latched MODE = 1: COUNT <= T0; STEP_IDX <= 0; WRAP = 1 for one cycle; stay in RUN.
REQ-029 Latency: COUNT SHALL reflect a step on the first edge at which STEP_EN is sampled high (one-cycle latency, no pipeline bubbles); back-to-back STEP_EN SHALL advance every cycle.
REQ-030 ABORT in RUN SHALL return the FSM to IDLE, hold COUNT and STEP_IDX, and generate no DONE; ABORT SHALL have priority over STEP_EN in the same cycle.
REQ-031 START during RUN and ABORT/STEP_EN during IDLE SHALL be ignored.
REQ-032 Input changes to T0, H, T_END and MODE during RUN SHALL have no effect.
REQ-033 COUNT SHALL remain stable in IDLE until the next accepted START.

Reset
REQ-034 RST SHALL have priority over all other inputs, including in the middle of a run.
REQ-035 Under RST: state = IDLE, COUNT = 0, STEP_IDX = 0, BUSY = 0, DONE = 0, WRAP = 0, ERR = 0, and all latched registers = 0.

Verification
REQ-036 Q16.16 stop run: T0 = 0, H = 0x0000_8000, T_END = 0x0002_0000, MODE 0, STEP_EN held high -> COUNT sequence 0x8000, 0x10000, 0x18000, 0x20000; DONE pulses once; STEP_IDX = 4; BUSY low afterwards.
REQ-037 Clamp: T0 = 0, H = 0x0000_C000, T_END = 0x0001_0000 -> COUNT sequence 0xC000, then 0x10000 (clamped); DONE pulses; STEP_IDX = 2.
REQ-038 Wrap mode: T0 = 0x0001_0000, H = 0x0001_0000, T_END = 0x0003_0000, MODE 1, 5 steps -> COUNT sequence 2.0, 1.0 (with WRAP pulse), 2.0, 1.0 (with WRAP pulse), 2.0; BUSY stays high; no DONE.
REQ-039 Large-value no-overflow: T0 = 0x7FFF_0000, H = 0x0002_0000, T_END = 0x7FFF_FFFF, MODE 0 -> one step gives COUNT = 0x7FFF_FFFF and DONE, with no negative wrap.
REQ-040 Errors/degenerate: H = 0xFFFF_0000 -> ERR = 1, BUSY = 0; T_END = T0 = 0x0001_0000 -> DONE pulse, COUNT = 0x0001_0000, no RUN.
REQ-041 Mid-run control: ABORT asserted together with STEP_EN after 2 steps -> IDLE, COUNT held, no DONE; RST asserted mid-run -> all outputs 0 on the next edge.
